// File: rtl/field_packer_pkg.sv
// Shared definitions for the field packer.
// Contents:
//   state_t      - packer FSM state (FILL accepts fields, FLUSH emits the residue word).
//   len_w(in_w)  - width of a field-length value that can hold 0..in_w.
//   cnt_w(out_w) - width of a bit count that can hold 0..out_w.
package field_packer_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    function automatic int len_w(input int in_w);
        return $clog2(in_w + 1);
    endfunction

    function automatic int cnt_w(input int out_w);
        return $clog2(out_w + 1);
    endfunction

endpackage

// File: rtl/field_packer_if.sv
// Field-in / word-out bus of the field packer.
// Handshake (both channels): a transfer happens on a rising clock edge where
// valid && ready are both 1. A producer holds its payload stable while valid is
// high and ready is low. Valid never waits for ready; ready may depend on valid.
// Signals:
//   InData/InLen/InLast/InValid -> packer, InReady <- packer   (field channel)
//   Out/OutBits/OutLast/OutValid <- packer, OutReady -> packer (word channel)
// The modport master is the side that produces fields and consumes words; slave is the packer.
interface field_packer_if #(
    parameter int OUT_W = 32,
    parameter int IN_W  = 8
);
    import field_packer_pkg::*;

    localparam int LEN_W = len_w(IN_W);
    localparam int CNT_W = cnt_w(OUT_W);

    logic [IN_W-1:0]  InData;
    logic [LEN_W-1:0] InLen;
    logic             InValid;
    logic             InLast;
    logic             InReady;
    logic [OUT_W-1:0] Out;
    logic [CNT_W-1:0] OutBits;
    logic             OutLast;
    logic             OutValid;
    logic             OutReady;

    modport master (
        output InData, InLen, InValid, InLast, OutReady,
        input  InReady, Out, OutBits, OutLast, OutValid
    );

    modport slave (
        input  InData, InLen, InValid, InLast, OutReady,
        output InReady, Out, OutBits, OutLast, OutValid
    );

endinterface

// File: rtl/packer_merge.sv
// Combinational merge of the left-justified accumulator with one new field.
// Ports:
//   acc_i     - pending bits, left-justified, low bits zero
//   fill_i    - number of pending bits (0..OUT_W-1)
//   data_i    - field payload, only the low len bits are used
//   len_i     - field length, values above IN_W are clamped to IN_W
//   word_o    - top OUT_W bits of {acc, field}
//   residue_o - bits that spilled past OUT_W, left-justified
//   total_o   - fill + clamped length
//   res_cnt_o - total - OUT_W (meaningful only when total >= OUT_W)
module packer_merge
    import field_packer_pkg::*;
#(
    parameter int OUT_W = 32,
    parameter int IN_W  = 8
) (
    input  logic [OUT_W-1:0]          acc_i,
    input  logic [cnt_w(OUT_W)-1:0]   fill_i,
    input  logic [IN_W-1:0]           data_i,
    input  logic [len_w(IN_W)-1:0]    len_i,
    output logic [OUT_W-1:0]          word_o,
    output logic [OUT_W-1:0]          residue_o,
    output logic [cnt_w(OUT_W):0]     total_o,
    output logic [cnt_w(OUT_W)-1:0]   res_cnt_o
);
    localparam int LEN_W = len_w(IN_W);
    localparam int CNT_W = cnt_w(OUT_W);
    localparam int WW    = 2 * OUT_W;

    logic [LEN_W-1:0]  len_c;
    logic [IN_W-1:0]   mask;
    logic [CNT_W:0]    shamt;
    logic [CNT_W:0]    res_full;
    logic [WW-1:0]     wide;

    always_comb begin
        len_c = (len_i > LEN_W'(IN_W)) ? LEN_W'(IN_W) : len_i;
        // Shifting by IN_W yields 0, so the subtraction gives all ones for a full-width field.
        mask    = (IN_W'(1) << len_c) - IN_W'(1);
        total_o = {1'b0, fill_i} + (CNT_W+1)'(len_c);
        // Place the field so its MSB lands right after the last pending bit.
        // WW fits in CNT_W+1 bits because 2^CNT_W > OUT_W.
        shamt    = (CNT_W+1)'(WW) - total_o;
        wide     = {acc_i, {OUT_W{1'b0}}}
                 | ({{(WW-IN_W){1'b0}}, data_i & mask} << shamt);
        word_o    = wide[WW-1:OUT_W];
        residue_o = wide[OUT_W-1:0];
        res_full  = total_o - (CNT_W+1)'(OUT_W);
        res_cnt_o = res_full[CNT_W-1:0];
    end

endmodule

// File: rtl/field_packer.sv
// Packs variable-length fields MSB-first into OUT_W-bit words, exactly like
// {field0, field1, ...}, emitting a zero-padded short word at message end.
// OUT_W must be >= IN_W; the bus interface must use the same parameters.
// Ports:
//   Clk      - clock, rising edge
//   Rst      - synchronous active-high reset
//   bus      - field_packer_if slave (field input and word output channels)
//   DbgState - current FSM state, for observation only
module field_packer
    import field_packer_pkg::*;
#(
    parameter int OUT_W = 32,
    parameter int IN_W  = 8
) (
    input  logic          Clk,
    input  logic          Rst,
    field_packer_if.slave bus,
    output state_t        DbgState
);
    localparam int CNT_W = cnt_w(OUT_W);

    state_t           state_q;
    logic [OUT_W-1:0] acc_q;
    logic [CNT_W-1:0] fill_q;
    logic [OUT_W-1:0] out_q;
    logic [CNT_W-1:0] bits_q;
    logic             last_q;
    logic             valid_q;

    logic [OUT_W-1:0] word;
    logic [OUT_W-1:0] residue;
    logic [CNT_W:0]   total;
    logic [CNT_W-1:0] res_cnt;
    logic             slot_free;
    logic             accept;

    packer_merge #(.OUT_W(OUT_W), .IN_W(IN_W)) u_merge (
        .acc_i     (acc_q),
        .fill_i    (fill_q),
        .data_i    (bus.InData),
        .len_i     (bus.InLen),
        .word_o    (word),
        .residue_o (residue),
        .total_o   (total),
        .res_cnt_o (res_cnt)
    );

    // The output register can take a new word this cycle if empty or being drained.
    assign slot_free   = !valid_q || bus.OutReady;
    assign bus.InReady = !Rst && (state_q == FILL) && slot_free;
    assign accept      = bus.InValid && bus.InReady;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= FILL;
            acc_q   <= '0;
            fill_q  <= '0;
            out_q   <= '0;
            bits_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (valid_q && bus.OutReady) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                FILL: begin
                    if (accept) begin
                        if (bus.InLast) begin
                            if (total == '0) begin
                                // Empty message end: nothing to emit.
                            end else if (total <= (CNT_W+1)'(OUT_W)) begin
                                out_q   <= word;
                                bits_q  <= total[CNT_W-1:0];
                                last_q  <= 1'b1;
                                valid_q <= 1'b1;
                                acc_q   <= '0;
                                fill_q  <= '0;
                            end else begin
                                // Full word now, residue word once the slot frees.
                                out_q   <= word;
                                bits_q  <= CNT_W'(OUT_W);
                                last_q  <= 1'b0;
                                valid_q <= 1'b1;
                                acc_q   <= residue;
                                fill_q  <= res_cnt;
                                state_q <= FLUSH;
                            end
                        end else if (total >= (CNT_W+1)'(OUT_W)) begin
                            out_q   <= word;
                            bits_q  <= CNT_W'(OUT_W);
                            last_q  <= 1'b0;
                            valid_q <= 1'b1;
                            acc_q   <= residue;
                            fill_q  <= res_cnt;
                        end else begin
                            acc_q  <= word;
                            fill_q <= total[CNT_W-1:0];
                        end
                    end
                end
                FLUSH: begin
                    if (slot_free) begin
                        out_q   <= acc_q;
                        bits_q  <= fill_q;
                        last_q  <= 1'b1;
                        valid_q <= 1'b1;
                        acc_q   <= '0;
                        fill_q  <= '0;
                        state_q <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign bus.Out      = out_q;
    assign bus.OutBits  = bits_q;
    assign bus.OutLast  = last_q;
    assign bus.OutValid = valid_q;
    assign DbgState     = state_q;

endmodule

// File: doc/field_packer.md
FIELD_PACKER -- requirements
Module: field_packer

Interface
REQ-001 Parameter OUT_W, 32, output word width in bits; SHALL satisfy OUT_W >= IN_W.
REQ-002 Parameter IN_W, 8, maximum field width in bits.
REQ-003 Derived LEN_W = clog2(IN_W+1), width of length fields; CNT_W = clog2(OUT_W+1), width of the fill count.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst  input  1  synchronous, active-high reset.
REQ-006 InData  input  IN_W  field payload; low InLen bits are significant.
REQ-007 InLen  input  LEN_W  field length 0..IN_W; values above IN_W are treated as IN_W.
REQ-008 InValid  input  1  field present.
REQ-009 InLast  input  1  final field of message; flush after it.
REQ-010 InReady  output  1  field accepted when InValid && InReady.
REQ-011 Out  output  OUT_W  packed word, MSB-aligned.
REQ-012 OutBits  output  CNT_W  number of valid bits in Out, 1..OUT_W.
REQ-013 OutLast  output  1  Out is the final word of the message.
REQ-014 OutValid  output  1  Out/OutBits/OutLast valid.
REQ-015 OutReady  input  1  word consumed when OutValid && OutReady.

Function
REQ-016 Packing order: the first accepted field occupies the most significant bits, and each field is MSB-first, identical to Verilog concatenation {field0, field1, ...}.
REQ-017 The accumulator holds Fill (0..OUT_W-1) pending bits, left-justified; the unused low bits SHALL be zero.
REQ-018 In state FILL, InReady SHALL be !OutValid || OutReady; in state FLUSH, InReady SHALL be 0.
REQ-019 On accept with Fill+Len < OUT_W and !InLast, the field is appended, Fill += Len, and no word is emitted.
REQ-020 On accept with Fill+Len >= OUT_W, the completed top OUT_W bits SHALL be registered to Out with OutValid=1 and OutBits=OUT_W on the next cycle (latency 1), and the residue Fill+Len-OUT_W is left-justified in the accumulator.
REQ-021 On accept with InLast and Fill+Len <= OUT_W, a single word SHALL be emitted with OutBits=Fill+Len, zero-padded low bits and OutLast=1; the accumulator is then cleared, with Fill=0.
REQ-022 On accept with InLast and Fill+Len > OUT_W, the full word is emitted with OutLast=0, FSM SHALL go FILL->FLUSH, and the residue word (OutBits=residue, OutLast=1) SHALL be loaded when the output slot frees; FLUSH->FILL then follows with Fill=0.
REQ-023 If InLast arrives with Fill+Len == 0, no word SHALL be emitted and the state is unchanged.
REQ-024 Out, OutBits and OutLast SHALL be held stable while OutValid && !OutReady.
REQ-025 OutValid SHALL clear after a handshake unless a new word is loaded in the same cycle; back-to-back words with OutReady=1 SHALL sustain one word per cycle.
REQ-026 A field with InLen=0 and !InLast SHALL be accepted and SHALL be a no-op.

Reset
REQ-027 While Rst=1 at a Clk edge: Out=0, OutBits=0, OutLast=0, OutValid=0, accumulator=0, Fill=0, state=FILL.
REQ-028 InReady SHALL be 0 during the reset cycle.
REQ-029 Reset mid-message SHALL discard partial bits and any pending output without emitting them.

Structure
REQ-030 Package field_packer_pkg SHALL hold the state enum (FILL, FLUSH) and the clog2-based width helper functions.
REQ-031 The combinational shift/merge (accumulator + field -> word + residue) SHALL be the sub-module packer_merge; the FSM, registers and handshake SHALL reside in field_packer.

Verification
REQ-032 Concat equivalence: OUT_W=32, IN_W=8; fields FF/8, AA/8, 55/8, 0/4, F/4 (InLast on the last field) -> one word Out=FFAA550F, OutBits=32, OutLast=1.
REQ-033 Partial flush: A1/8, B2/8, C3/8 (InLast on C3) -> Out=A1B2C300, OutBits=24, OutLast=1.
REQ-034 Overflow on last: FF/8, FF/8, FF/8, F/4, then AB/8 with InLast -> FFFFFFFA (OutBits 32, OutLast 0), then B0000000 (OutBits 4, OutLast 1); InReady=0 while in FLUSH.
REQ-035 Backpressure: OutReady=0 for 5 cycles with a word pending -> Out stable, InReady=0; then OutReady=1 -> the word is consumed and the next field is accepted in the same cycle.
REQ-036 Reset mid-word: after 12/8, 34/8, assert Rst for 1 cycle, then send 56/8 with InLast -> Out=56000000, OutBits=8.
REQ-037 Empty last: with Fill=0, send InLen=0 with InLast -> no OutValid for 3 cycles.
